mux_scan_seq: RTL and testbench
===============================

Name: mux_scan_seq

Overview:
Parametrised N-channel multiplexer with a registered output and built-in one-hot channel decode. It has two modes: manual, where an external select drives the mux, and auto-scan, where an internal sequencer sweeps all channels with a programmable dwell time. It is the sequential successor of the team's 4:1 mux / 2:4 decoder pair, and feeds downstream sampling/display logic with valid/wrap strobes.

Parameters:
WIDTH, 1, bits per channel
SEL_W, 2, select width; CHANNELS = 2**SEL_W (derived localparam, not overridable)
DW_W, 8, width of the dwell input / dwell counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_bus  input  WIDTH*CHANNELS  channel k occupies bits [k*WIDTH +: WIDTH]
mode  input  1  0 = manual, 1 = auto-scan
sel_in  input  SEL_W  manual channel select
hold  input  1  auto mode only: freeze the sequencer
dwell  input  DW_W  auto mode: extra cycles per channel (period = dwell+1)
data_out  output  WIDTH  registered selected channel data
sel_out  output  SEL_W  channel index of data_out
dec_out  output  CHANNELS  one-hot decode of sel_out
valid  output  1  data_out updated this cycle
wrap  output  1  auto mode: the sample just taken was channel CHANNELS-1

Behaviour:
- One clock; reset is synchronous and active-high; rst has priority over every other input.
- Reset values: data_out=0, sel_out=0, dec_out=1 (bit 0 set), valid=0, wrap=0. Internal: cur=0, cnt=0, mode_q=0.
- mode_q is a registered copy of mode and is updated every non-reset cycle.
- Manual mode (mode=0), every cycle:
  - data_out<=in_bus[sel_in]; sel_out<=sel_in; dec_out<=onehot(sel_in); valid<=1; wrap<=0.
  - Latency is 1 cycle. hold and dwell are ignored.
- Auto-scan entry (mode=1 and mode_q=0):
  - cur<=0, cnt<=0, valid<=0, wrap<=0.
  - data_out, sel_out and dec_out hold their values.
- Auto-scan (mode=1 and mode_q=1):
  - hold=1: cur and cnt frozen; valid<=0; wrap<=0; other outputs hold.
  - hold=0 and cnt>=dwell (advance):
    - data_out<=in_bus[cur]; sel_out<=cur; dec_out<=onehot(cur); valid<=1.
    - wrap<=(cur==CHANNELS-1).
    - cur<=cur+1 modulo CHANNELS (natural SEL_W wrap); cnt<=0.
  - hold=0 and cnt<dwell: cnt<=cnt+1; valid<=0; wrap<=0.
  - The >= comparison means that lowering dwell below the current cnt advances on the next edge.
  - dwell=0 advances every cycle (valid continuously high).
- Scan period is dwell+1 cycles per channel. The first valid appears on the (dwell+1)-th edge after the entry edge.
- Auto→manual switch: manual behaviour applies on the very next edge. The auto sequencer state is discarded, and re-entry restarts at channel 0.
- valid and wrap are single-cycle strobes in auto mode. wrap is never high without valid.
- dec_out is always exactly one-hot, including during and after reset.
- No combinational path from inputs to outputs.

Test Plan:
1. Manual: in_bus=4'h8, sel_in=0,1,2,3 on consecutive cycles → one cycle later data_out=0,0,0,1; dec_out=0001,0010,0100,1000; valid=1 throughout; wrap=0.
2. Auto, dwell=0, in_bus=4'b1010 → from the 1st edge after entry: valid every cycle; sel_out=0,1,2,3,0; data_out=0,1,0,1,0; wrap=1 only alongside sel_out=3.
3. Auto, dwell=2 → valid high exactly on edges 3, 6, 9, 12 after entry; sel_out=0,1,2,3; wrap on the 4th strobe; valid=0 on all other cycles.
4. Auto, dwell=4, hold=1 for 5 cycles starting when cnt=2 → no valid during hold; after release, valid after 3 more edges (cnt 2→3→4→advance) with the same channel as before the hold.
5. rst=1 for one cycle while auto at cur=2 with mode held at 1 → next cycle all outputs at reset values. The following edge is treated as auto entry, and the scan restarts at channel 0.
6. Auto, dwell=5, at cnt=3 change dwell to 1 → advance (valid=1) on the next edge; subsequent period is 2 cycles.

Source files
------------

// File: rtl/mux_scan_seq.sv
// mux_scan_seq
// Parametrised N-channel multiplexer with a registered output and one-hot
// channel decode. In manual mode an external select picks the channel; in
// auto-scan mode an internal sequencer sweeps every channel in order and
// stays on each one for dwell+1 cycles.
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous reset, active-high, overrides every other input
//   in_bus   : packed channel data, channel k at [k*WIDTH +: WIDTH]
//   mode     : 0 = manual, 1 = auto-scan
//   sel_in   : manual channel select
//   hold     : auto mode, freezes the sequencer
//   dwell    : auto mode, extra cycles spent on each channel
//   data_out : registered data of the selected channel
//   sel_out  : channel index of data_out
//   dec_out  : one-hot decode of sel_out
//   valid    : data_out was refreshed on the last edge
//   wrap     : auto mode, the refresh just taken was the last channel

module mux_scan_seq #(
   parameter int WIDTH = 1,
   parameter int SEL_W = 2,
   parameter int DW_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH*(2**SEL_W)-1:0]   in_bus,
   input  logic                          mode,
   input  logic [SEL_W-1:0]              sel_in,
   input  logic                          hold,
   input  logic [DW_W-1:0]               dwell,
   output logic [WIDTH-1:0]              data_out,
   output logic [SEL_W-1:0]              sel_out,
   output logic [(2**SEL_W)-1:0]         dec_out,
   output logic                          valid,
   output logic                          wrap
);

   localparam int CHANNELS = 2**SEL_W;

   logic [WIDTH-1:0]    chan [CHANNELS];

   logic [WIDTH-1:0]    data_q,  data_d;
   logic [SEL_W-1:0]    sel_q,   sel_d;
   logic [CHANNELS-1:0] dec_q,   dec_d;
   logic                valid_q, valid_d;
   logic                wrap_q,  wrap_d;
   logic [SEL_W-1:0]    cur_q,   cur_d;
   logic [DW_W-1:0]     cnt_q,   cnt_d;
   logic                mode_q,  mode_d;

   // Unpack the flat bus into an array so channels can be indexed directly.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      assign chan[k] = in_bus[k*WIDTH +: WIDTH];
   end

   function automatic logic [CHANNELS-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [CHANNELS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Next-state logic. Outputs hold by default and the strobes default low,
   // so only the cycles that actually take a sample touch data/sel/dec.
   // The advance test uses >= so that lowering dwell below the running
   // count moves on at the next edge instead of waiting for a counter wrap.
   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      dec_d   = dec_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      mode_d  = mode;

      if (!mode) begin
         data_d  = chan[sel_in];
         sel_d   = sel_in;
         dec_d   = onehot(sel_in);
         valid_d = 1'b1;
         cur_d   = '0;
         cnt_d   = '0;
      end else if (!mode_q) begin
         cur_d = '0;
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q >= dwell) begin
            data_d  = chan[cur_q];
            sel_d   = cur_q;
            dec_d   = onehot(cur_q);
            valid_d = 1'b1;
            wrap_d  = (cur_q == SEL_W'(CHANNELS - 1));
            cur_d   = cur_q + SEL_W'(1);
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + DW_W'(1);
         end
      end
   end

   // State register with synchronous reset; dec resets to channel 0 so the
   // decode stays one-hot at all times.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         sel_q   <= '0;
         dec_q   <= CHANNELS'(1);
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         cur_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         dec_q   <= dec_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   assign data_out = data_q;
   assign sel_out  = sel_q;
   assign dec_out  = dec_q;
   assign valid    = valid_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq
// Self-checking bench for mux_scan_seq with default parameters (4 channels,
// 1-bit data). Directed scenarios use literal expectations; randomized
// scenarios are compared with a reference model that derives each sample
// from the number of unheld auto cycles since entry.

module tb_mux_scan_seq;

   localparam int WIDTH    = 1;
   localparam int SEL_W    = 2;
   localparam int DW_W     = 8;
   localparam int CHANNELS = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [WIDTH*CHANNELS-1:0] in_bus;
   logic                      mode;
   logic [SEL_W-1:0]          sel_in;
   logic                      hold;
   logic [DW_W-1:0]           dwell;
   logic [WIDTH-1:0]          data_out;
   logic [SEL_W-1:0]          sel_out;
   logic [CHANNELS-1:0]       dec_out;
   logic                      valid;
   logic                      wrap;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [WIDTH-1:0] exp_data;
   logic [SEL_W-1:0] exp_sel;
   logic             exp_valid;
   logic             exp_wrap;
   bit               m_auto;
   int               m_n;

   mux_scan_seq #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DW_W(DW_W)) dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .mode(mode), .sel_in(sel_in),
      .hold(hold), .dwell(dwell), .data_out(data_out), .sel_out(sel_out),
      .dec_out(dec_out), .valid(valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   // Model: in auto mode every unheld edge after entry is one elapsed cycle;
   // a sample is due whenever the elapsed count is a multiple of dwell+1,
   // and the k-th sample reads channel (k-1) mod CHANNELS.
   task automatic model_edge();
      int k;
      int ch;
      if (rst) begin
         exp_data = '0; exp_sel = '0; exp_valid = 1'b0; exp_wrap = 1'b0;
         m_auto = 1'b0; m_n = 0;
      end else if (!mode) begin
         exp_data  = in_bus[int'(sel_in)*WIDTH +: WIDTH];
         exp_sel   = sel_in;
         exp_valid = 1'b1;
         exp_wrap  = 1'b0;
         m_auto    = 1'b0;
      end else if (!m_auto) begin
         m_auto = 1'b1; m_n = 0; exp_valid = 1'b0; exp_wrap = 1'b0;
      end else if (hold) begin
         exp_valid = 1'b0; exp_wrap = 1'b0;
      end else begin
         m_n++;
         if (m_n % (int'(dwell) + 1) == 0) begin
            k         = m_n / (int'(dwell) + 1);
            ch        = (k - 1) % CHANNELS;
            exp_data  = in_bus[ch*WIDTH +: WIDTH];
            exp_sel   = SEL_W'(ch);
            exp_valid = 1'b1;
            exp_wrap  = (ch == CHANNELS - 1);
         end else begin
            exp_valid = 1'b0; exp_wrap = 1'b0;
         end
      end
   endtask

   // One clock edge; outputs are stable and inputs may be changed on return.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode = 1'b1; hold = 1'b0; dwell = 8'd0;
      in_bus = 4'hF; sel_in = 2'd3;
      tick();
      tick();
      n_checks++;
      if (data_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_data got %0h want 0", data_out); end
      n_checks++;
      if (sel_out !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_sel got %0d want 0", sel_out); end
      n_checks++;
      if (dec_out !== 4'b0001) begin n_fail++; $display("[TB] FAIL reset_dec got %b want 0001", dec_out); end
      n_checks++;
      if (valid !== 1'b0 || wrap !== 1'b0) begin
         n_fail++; $display("[TB] FAIL reset_strobes got valid=%b wrap=%b want 0 0", valid, wrap);
      end
      rst = 1'b0;
   endtask

   task automatic test_manual();
      logic [3:0] want_dec;
      mode = 1'b0; in_bus = 4'h8; hold = 1'b1; dwell = 8'd3;
      for (int s = 0; s < CHANNELS; s++) begin
         sel_in = SEL_W'(s);
         tick();
         want_dec = 4'b0001 << s;
         n_checks++;
         if (data_out !== WIDTH'(s == 3) || dec_out !== want_dec || sel_out !== SEL_W'(s)) begin
            n_fail++;
            $display("[TB] FAIL manual_sel%0d got data=%0h sel=%0d dec=%b want data=%0d sel=%0d dec=%b",
                     s, data_out, sel_out, dec_out, (s == 3), s, want_dec);
         end
         n_checks++;
         if (valid !== 1'b1 || wrap !== 1'b0) begin
            n_fail++; $display("[TB] FAIL manual_strobes%0d got valid=%b wrap=%b want 1 0", s, valid, wrap);
         end
      end
      for (int i = 0; i < 40; i++) begin
         in_bus = 4'($urandom); sel_in = 2'($urandom); hold = 1'($urandom); dwell = 8'($urandom);
         tick();
         n_checks++;
         if (data_out !== exp_data || sel_out !== exp_sel || dec_out !== (4'b0001 << exp_sel)
             || valid !== exp_valid || wrap !== exp_wrap) begin
            n_fail++;
            $display("[TB] FAIL manual_rand%0d got d=%0h s=%0d dec=%b v=%b w=%b want d=%0h s=%0d v=%b w=%b",
                     i, data_out, sel_out, dec_out, valid, wrap, exp_data, exp_sel, exp_valid, exp_wrap);
         end
      end
   endtask

   task automatic test_auto_dwell0();
      mode = 1'b0; sel_in = 2'd0; in_bus = 4'b1010; hold = 1'b0; dwell = 8'd0;
      tick();
      mode = 1'b1;
      tick();
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dwell0_entry valid got %b want 0", valid); end
      for (int e = 0; e < 5; e++) begin
         tick();
         n_checks++;
         if (valid !== 1'b1 || sel_out !== SEL_W'(e % 4) || data_out !== WIDTH'(e % 2)
             || wrap !== 1'((e % 4) == 3) || dec_out !== (4'b0001 << (e % 4))) begin
            n_fail++;
            $display("[TB] FAIL dwell0_edge%0d got v=%b s=%0d d=%0h w=%b dec=%b want v=1 s=%0d d=%0d w=%0d",
                     e + 1, valid, sel_out, data_out, wrap, dec_out, e % 4, e % 2, (e % 4) == 3);
         end
      end
   endtask

   task automatic test_auto_dwell2();
      mode = 1'b0; sel_in = 2'd1; in_bus = 4'b0110; hold = 1'b0; dwell = 8'd2;
      tick();
      mode = 1'b1;
      tick();
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if (valid !== 1'((e % 3) == 0) || wrap !== 1'(e == 12)) begin
            n_fail++;
            $display("[TB] FAIL dwell2_edge%0d got valid=%b wrap=%b want valid=%0d wrap=%0d",
                     e, valid, wrap, (e % 3) == 0, e == 12);
         end
         if ((e % 3) == 0) begin
            n_checks++;
            if (sel_out !== SEL_W'(e / 3 - 1)) begin
               n_fail++; $display("[TB] FAIL dwell2_sel%0d got %0d want %0d", e, sel_out, e / 3 - 1);
            end
         end
      end
   endtask

   task automatic test_hold();
      mode = 1'b0; sel_in = 2'd2; in_bus = 4'b0001; hold = 1'b0; dwell = 8'd4;
      tick();
      mode = 1'b1;
      tick();
      tick();
      tick();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'b0 || sel_out !== 2'd2 || data_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hold_cycle%0d got valid=%b sel=%0d data=%0h want 0 2 0", i, valid, sel_out, data_out);
         end
      end
      hold = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'(i == 3)) begin
            n_fail++; $display("[TB] FAIL hold_release%0d valid got %b want %0d", i, valid, i == 3);
         end
      end
      n_checks++;
      if (sel_out !== 2'd0 || data_out !== 1'b1) begin
         n_fail++; $display("[TB] FAIL hold_channel got sel=%0d data=%0h want 0 1", sel_out, data_out);
      end
   endtask

   task automatic test_reset_in_auto();
      mode = 1'b0; sel_in = 2'd3; in_bus = 4'b1111; hold = 1'b0; dwell = 8'd0;
      tick();
      mode = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (data_out !== 1'b0 || sel_out !== 2'd0 || dec_out !== 4'b0001 || valid !== 1'b0 || wrap !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_in_auto got d=%0h s=%0d dec=%b v=%b w=%b want 0 0 0001 0 0",
                  data_out, sel_out, dec_out, valid, wrap);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (valid !== 1'b0 || data_out !== 1'b0 || dec_out !== 4'b0001) begin
         n_fail++; $display("[TB] FAIL rst_reentry got v=%b d=%0h dec=%b want 0 0 0001", valid, data_out, dec_out);
      end
      tick();
      n_checks++;
      if (valid !== 1'b1 || sel_out !== 2'd0 || data_out !== 1'b1) begin
         n_fail++; $display("[TB] FAIL rst_restart got v=%b s=%0d d=%0h want 1 0 1", valid, sel_out, data_out);
      end
   endtask

   task automatic test_dwell_change();
      mode = 1'b0; sel_in = 2'd2; in_bus = 4'b0010; hold = 1'b0; dwell = 8'd5;
      tick();
      mode = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dwchg_pre%0d valid got %b want 0", i, valid); end
      end
      dwell = 8'd1;
      tick();
      n_checks++;
      if (valid !== 1'b1 || sel_out !== 2'd0) begin
         n_fail++; $display("[TB] FAIL dwchg_advance got v=%b s=%0d want 1 0", valid, sel_out);
      end
      tick();
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dwchg_gap valid got %b want 0", valid); end
      tick();
      n_checks++;
      if (valid !== 1'b1 || sel_out !== 2'd1 || data_out !== 1'b1) begin
         n_fail++; $display("[TB] FAIL dwchg_next got v=%b s=%0d d=%0h want 1 1 1", valid, sel_out, data_out);
      end
   endtask

   task automatic test_back_to_back();
      mode = 1'b0; sel_in = 2'd0; in_bus = 4'b1000; hold = 1'b0; dwell = 8'd0;
      tick();
      mode = 1'b1;
      tick();
      tick();
      tick();
      mode = 1'b0; sel_in = 2'd3;
      tick();
      n_checks++;
      if (valid !== 1'b1 || sel_out !== 2'd3 || data_out !== 1'b1 || wrap !== 1'b0) begin
         n_fail++; $display("[TB] FAIL b2b_manual got v=%b s=%0d d=%0h w=%b want 1 3 1 0", valid, sel_out, data_out, wrap);
      end
      mode = 1'b1;
      tick();
      n_checks++;
      if (valid !== 1'b0 || sel_out !== 2'd3 || data_out !== 1'b1) begin
         n_fail++; $display("[TB] FAIL b2b_entry got v=%b s=%0d d=%0h want 0 3 1", valid, sel_out, data_out);
      end
      tick();
      n_checks++;
      if (valid !== 1'b1 || sel_out !== 2'd0 || data_out !== 1'b0) begin
         n_fail++; $display("[TB] FAIL b2b_restart got v=%b s=%0d d=%0h want 1 0 0", valid, sel_out, data_out);
      end
   endtask

   task automatic test_random_auto();
      rst = 1'b1; mode = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 600; i++) begin
         in_bus = 4'($urandom);
         sel_in = 2'($urandom);
         hold   = ($urandom_range(0, 3) == 0);
         rst    = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if (!mode) dwell = 8'($urandom_range(0, 3));
         tick();
         n_checks++;
         if (data_out !== exp_data || sel_out !== exp_sel || dec_out !== (4'b0001 << exp_sel)
             || valid !== exp_valid || wrap !== exp_wrap) begin
            n_fail++;
            $display("[TB] FAIL auto_rand%0d got d=%0h s=%0d dec=%b v=%b w=%b want d=%0h s=%0d v=%b w=%b",
                     i, data_out, sel_out, dec_out, valid, wrap, exp_data, exp_sel, exp_valid, exp_wrap);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel_in = '0; hold = 1'b0; dwell = '0; in_bus = '0;
      m_auto = 1'b0; m_n = 0;
      exp_data = '0; exp_sel = '0; exp_valid = 1'b0; exp_wrap = 1'b0;
      test_reset();
      test_manual();
      test_auto_dwell0();
      test_auto_dwell2();
      test_hold();
      test_reset_in_auto();
      test_dwell_change();
      test_back_to_back();
      test_random_auto();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
